// File: rtl/radix4_booth_multiplier.sv
// Multi-cycle radix-4 (modified Booth) multiplier: one Booth digit per cycle, full 2*NUM_BITS product.
// Optional build macro RADIX4_MUL_ZERO_SKIP_EN: zero operands complete one cycle after start, with no RUN cycles.
module radix4_booth_multiplier #(
    parameter int NUM_BITS = 32
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    start,
    input  logic                    is_signed_a,
    input  logic                    is_signed_b,
    input  logic [NUM_BITS-1:0]     multiplicand,
    input  logic [NUM_BITS-1:0]     multiplier,
    output logic [2*NUM_BITS-1:0]   product,
    output logic                    finished
);

    localparam int EXT_W = NUM_BITS + 2;
    localparam int ACC_W = NUM_BITS + 4;
    localparam int CNT_W = $clog2(NUM_BITS/2 + 2);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(NUM_BITS/2 + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ACC_W-1:0] ACC_ONE  = {{(ACC_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;
    logic [EXT_W-1:0]         a_r;
    logic [EXT_W-1:0]         b_r;
    logic                     guard_r;
    logic [ACC_W-1:0]         acc_r;
    logic [CNT_W-1:0]         count_r;
    logic [2*NUM_BITS-1:0]    product_r;
    logic                     finished_r;
    logic [ACC_W-1:0]         a_wide_s;
    logic [ACC_W-1:0]         pp_s;
    logic [ACC_W-1:0]         sum_s;
    logic [ACC_W-1:0]         acc_nx_s;
    logic [EXT_W-1:0]         b_nx_s;
    logic                     last_s;
    logic                     start_zero_s;
`ifdef RADIX4_MUL_ZERO_SKIP_EN
    logic                     skip_pend_r;
`endif

    assign product  = product_r;
    assign finished = finished_r;

`ifdef RADIX4_MUL_ZERO_SKIP_EN
    assign start_zero_s = start && ((multiplicand == {NUM_BITS{1'b0}}) || (multiplier == {NUM_BITS{1'b0}}));
`else
    assign start_zero_s = 1'b0;
`endif

    // Booth digit selection, accumulate, and the 2-bit arithmetic shift of {acc, b, guard}
    always_comb begin
        a_wide_s = {{2{a_r[EXT_W-1]}}, a_r};
        pp_s     = {ACC_W{1'b0}};
        case ({b_r[1:0], guard_r})
            3'b000, 3'b111: pp_s = {ACC_W{1'b0}};
            3'b001, 3'b010: pp_s = a_wide_s;
            3'b011:         pp_s = {a_wide_s[ACC_W-2:0], 1'b0};
            3'b100:         pp_s = ~{a_wide_s[ACC_W-2:0], 1'b0} + ACC_ONE;
            3'b101, 3'b110: pp_s = ~a_wide_s + ACC_ONE;
            default:        pp_s = {ACC_W{1'b0}};
        endcase
        sum_s    = acc_r + pp_s;
        acc_nx_s = {{2{sum_s[ACC_W-1]}}, sum_s[ACC_W-1:2]};
        b_nx_s   = {sum_s[1:0], b_r[EXT_W-1:2]};
        last_s   = (count_r == CNT_ONE);
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; start always wins, including as an abort in RUN
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_next_s = start_zero_s ? DONE : RUN;
                end else begin
                    state_next_s = state_r;
                end
            end
            RUN: begin
                if (start) begin
                    state_next_s = start_zero_s ? DONE : RUN;
                end else if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath: operand capture, per-digit iteration, and registered result
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            a_r        <= {EXT_W{1'b0}};
            b_r        <= {EXT_W{1'b0}};
            guard_r    <= 1'b0;
            acc_r      <= {ACC_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            product_r  <= {(2*NUM_BITS){1'b0}};
            finished_r <= 1'b0;
`ifdef RADIX4_MUL_ZERO_SKIP_EN
            skip_pend_r <= 1'b0;
`endif
        end else if (start) begin
            a_r        <= {{2{is_signed_a & multiplicand[NUM_BITS-1]}}, multiplicand};
            b_r        <= {{2{is_signed_b & multiplier[NUM_BITS-1]}}, multiplier};
            guard_r    <= 1'b0;
            acc_r      <= {ACC_W{1'b0}};
            count_r    <= CNT_INIT;
            finished_r <= 1'b0;
`ifdef RADIX4_MUL_ZERO_SKIP_EN
            skip_pend_r <= start_zero_s;
`endif
        end else if (state_r == RUN) begin
            acc_r   <= acc_nx_s;
            b_r     <= b_nx_s;
            guard_r <= b_r[1];
            count_r <= count_r - CNT_ONE;
            if (last_s) begin
                // After the final shift, b holds the low bits and acc the high bits of the product
                product_r  <= {acc_nx_s[NUM_BITS-3:0], b_nx_s};
                finished_r <= 1'b1;
            end
`ifdef RADIX4_MUL_ZERO_SKIP_EN
        end else if (skip_pend_r) begin
            product_r   <= {(2*NUM_BITS){1'b0}};
            finished_r  <= 1'b1;
            skip_pend_r <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_radix4_booth_multiplier.sv
// Directed, table-driven bench for radix4_booth_multiplier plus abort and mid-operation reset sequences.
module tb_radix4_booth_multiplier;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        start;
    logic        is_signed_a;
    logic        is_signed_b;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [63:0] product;
    logic        finished;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sa;
        logic        sb;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[13];

    radix4_booth_multiplier #(.NUM_BITS(32)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .start        (start),
        .is_signed_a  (is_signed_a),
        .is_signed_b  (is_signed_b),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .finished     (finished)
    );

    always #5 CLK = ~CLK;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Pulse start for one edge; returns #1 after the sampling edge
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb);
        @(negedge CLK);
        multiplicand = a;
        multiplier   = b;
        is_signed_a  = sa;
        is_signed_b  = sb;
        start        = 1'b1;
        @(posedge CLK);
        #1;
        start        = 1'b0;
        multiplicand = 32'h5A5A_A5A5;
        multiplier   = 32'hC3C3_3C3C;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge CLK);
            #1;
            if (finished) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        int          exp_lat;
        logic        bad_flag;
        logic        saw_2a;
        logic [63:0] prev_prod;

        vecs[0]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001};
        vecs[1]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000};
        vecs[2]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001};
        vecs[3]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFD_0000_0003};
        vecs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'h8000_0000_8000_0000};
        vecs[5]  = '{32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 64'h8000_0000_8000_0000};
        vecs[6]  = '{32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[7]  = '{32'h0000_FFFF, 32'h0001_0001, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF};
        vecs[8]  = '{32'hFFFF_FFF9, 32'h0000_0003, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[9]  = '{32'h8000_0000, 32'h0000_0002, 1'b0, 1'b0, 64'h0000_0001_0000_0000};
        vecs[10] = '{32'h1234_5678, 32'h0000_0010, 1'b1, 1'b1, 64'h0000_0001_2345_6780};
        vecs[11] = '{32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'h0000_0000_0000_0000};
        vecs[12] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0, 64'h0000_0000_0000_000F};

        nRST = 1'b0; start = 1'b0; is_signed_a = 1'b0; is_signed_b = 1'b0;
        multiplicand = 32'h0; multiplier = 32'h0;
        repeat (3) @(posedge CLK);
        #1;
        check64("reset_finished", {63'h0, finished}, 64'h0);
        check64("reset_product", product, 64'h0);
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < 13; i++) begin
            exp_lat = 17;
`ifdef RADIX4_MUL_ZERO_SKIP_EN
            if (vecs[i].a == 32'h0 || vecs[i].b == 32'h0) exp_lat = 1;
`endif
            launch(vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb);
            check64($sformatf("v%0d_fin_low", i), {63'h0, finished}, 64'h0);
            wait_done(lat);
            check64($sformatf("v%0d_latency", i), 64'(lat), 64'(exp_lat));
            check64($sformatf("v%0d_product", i), product, vecs[i].exp);
        end

        // Abort: 7*6 is replaced 5 cycles in; its 0x2A must never show
        prev_prod = product;
        bad_flag  = 1'b0;
        saw_2a    = 1'b0;
        launch(32'd7, 32'd6, 1'b0, 1'b0);
        repeat (4) begin
            @(posedge CLK);
            #1;
            if (finished || product !== prev_prod) bad_flag = 1'b1;
        end
        launch(32'h1234_5678, 32'h0000_0010, 1'b1, 1'b1);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            if (product == 64'h2A) saw_2a = 1'b1;
            if (!finished && product !== prev_prod) bad_flag = 1'b1;
            @(posedge CLK);
            #1;
            if (finished) begin
                lat = c;
                break;
            end
        end
        if (product == 64'h2A) saw_2a = 1'b1;
        check64("abort_hold", {63'h0, bad_flag}, 64'h0);
        check64("abort_no_2a", {63'h0, saw_2a}, 64'h0);
        check64("abort_latency", 64'(lat), 64'd17);
        check64("abort_product", product, 64'h0000_0001_2345_6780);

        // Reset in the middle of a 5*9 operation
        launch(32'd5, 32'd9, 1'b0, 1'b0);
        repeat (7) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b0;
        @(posedge CLK);
        #1;
        check64("rst_mid_finished", {63'h0, finished}, 64'h0);
        check64("rst_mid_product", product, 64'h0);
        @(negedge CLK);
        nRST = 1'b1;
        bad_flag = 1'b0;
        repeat (25) begin
            @(posedge CLK);
            #1;
            if (finished || product !== 64'h0) bad_flag = 1'b1;
        end
        check64("rst_mid_stays_idle", {63'h0, bad_flag}, 64'h0);
        launch(32'd5, 32'd9, 1'b0, 1'b0);
        wait_done(lat);
        check64("rst_after_latency", 64'(lat), 64'd17);
        check64("rst_after_product", product, 64'h2D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
